// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - hazard, stall, flush and forwarding controller for the 5-stage pipeline
//
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   rs1_d, rs2_d          decode-stage source registers
//   rs1_e, rs2_e, rd_e    execute-stage source/destination registers
//   load_e, pc_src_e      execute-stage load flag and taken redirect
//   rd_m, reg_write_m     memory-stage destination and write enable
//   mem_req_m, mem_ready  data-memory request and completion handshake
//   rd_w, reg_write_w     writeback-stage destination and write enable
//   en_f..en_w            pipeline register enables (PC, IF/ID, ID/EX, EX/MEM, MEM/WB)
//   flush_d, flush_e      IF/ID and ID/EX synchronous clears
//   forward_a_e/_b_e      EX operand selects (00 regfile, 01 W result, 10 M result)
//   mem_timeout           sticky data-memory timeout flag
//   stall_cycles          saturating count of cycles with en_f low
module pipeline_ctrl #(
    parameter int MAX_WAIT = 64,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       rs1_d,
    input  logic [4:0]       rs2_d,
    input  logic [4:0]       rs1_e,
    input  logic [4:0]       rs2_e,
    input  logic [4:0]       rd_e,
    input  logic             load_e,
    input  logic             pc_src_e,
    input  logic [4:0]       rd_m,
    input  logic             reg_write_m,
    input  logic             mem_req_m,
    input  logic             mem_ready,
    input  logic [4:0]       rd_w,
    input  logic             reg_write_w,
    output logic             en_f,
    output logic             en_d,
    output logic             en_e,
    output logic             en_m,
    output logic             en_w,
    output logic             flush_d,
    output logic             flush_e,
    output logic [1:0]       forward_a_e,
    output logic [1:0]       forward_b_e,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cycles
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } state_t;

    localparam logic [15:0]      WAIT_LAST = 16'(MAX_WAIT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    state_t      state;
    state_t      state_next;
    logic [15:0] wait_cnt;
    logic [15:0] wait_cnt_next;
    logic        mem_timeout_next;
    logic        mem_stall;
    logic        lu_hazard;

    // M result is newer than W result, so it wins when both match.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic [4:0] m_rd,
        input logic       m_we,
        input logic [4:0] w_rd,
        input logic       w_we
    );
        if (m_we && (m_rd != 5'd0) && (m_rd == rs)) begin
            return 2'b10;
        end else if (w_we && (w_rd != 5'd0) && (w_rd == rs)) begin
            return 2'b01;
        end
        return 2'b00;
    endfunction

    always_comb begin
        mem_stall = mem_req_m & ~mem_ready;
        lu_hazard = load_e & (rd_e != 5'd0) & ((rd_e == rs1_d) | (rd_e == rs2_d));
    end

    // Enable/flush priority: reset, error, memory stall, redirect, load-use.
    // A redirect seen during a memory stall is not consumed here; the frozen
    // EX stage keeps presenting it until the stall releases.
    always_comb begin
        en_f        = 1'b1;
        en_d        = 1'b1;
        en_e        = 1'b1;
        en_m        = 1'b1;
        en_w        = 1'b1;
        flush_d     = 1'b0;
        flush_e     = 1'b0;
        forward_a_e = 2'b00;
        forward_b_e = 2'b00;
        if (reset) begin
            {en_f, en_d, en_e, en_m, en_w} = 5'b00000;
            flush_d = 1'b1;
            flush_e = 1'b1;
        end else begin
            forward_a_e = fwd_sel(rs1_e, rd_m, reg_write_m, rd_w, reg_write_w);
            forward_b_e = fwd_sel(rs2_e, rd_m, reg_write_m, rd_w, reg_write_w);
            if (state == ERROR || mem_stall) begin
                {en_f, en_d, en_e, en_m, en_w} = 5'b00000;
            end else if (pc_src_e) begin
                flush_d = 1'b1;
                flush_e = 1'b1;
            end else if (lu_hazard) begin
                en_f    = 1'b0;
                en_d    = 1'b0;
                flush_e = 1'b1;
            end
        end
    end

    // wait_cnt holds the number of wait cycles already seen before the
    // current one, so the MAX_WAIT-th wait cycle sees MAX_WAIT-1.
    always_comb begin
        state_next       = state;
        wait_cnt_next    = wait_cnt;
        mem_timeout_next = mem_timeout;
        case (state)
            RUN: begin
                if (mem_stall) begin
                    state_next    = MEM_WAIT;
                    wait_cnt_next = 16'd1;
                end
            end
            MEM_WAIT: begin
                if (!mem_stall) begin
                    state_next    = RUN;
                    wait_cnt_next = 16'd0;
                end else if (wait_cnt == WAIT_LAST) begin
                    state_next       = ERROR;
                    mem_timeout_next = 1'b1;
                end else begin
                    wait_cnt_next = wait_cnt + 16'd1;
                end
            end
            ERROR: begin
                mem_timeout_next = 1'b1;
            end
            default: begin
                state_next    = RUN;
                wait_cnt_next = 16'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= RUN;
            wait_cnt     <= 16'd0;
            mem_timeout  <= 1'b0;
            stall_cycles <= '0;
        end else begin
            state       <= state_next;
            wait_cnt    <= wait_cnt_next;
            mem_timeout <= mem_timeout_next;
            if (!en_f && (stall_cycles != CNT_MAX)) begin
                stall_cycles <= stall_cycles + 1'b1;
            end
        end
    end

endmodule
